// File: rtl/adder.sv
// Registered WIDTH-bit adder: a + b + cin with carry-out, full (WIDTH+1)-bit result,
// signed overflow and zero flags, all qualified by a one-cycle-latency valid.
module adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [WIDTH:0]   result,
  output logic             overflow,
  output logic             zero,
  output logic             out_valid
);

  function automatic logic signed_overflow(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  logic [WIDTH:0] full_s;
  logic           overflow_s;
  logic           zero_s;

  logic [WIDTH:0] result_r;
  logic           overflow_r;
  logic           zero_r;
  logic           out_valid_r;

  // Full-precision sum of zero-extended operands and the flags derived from it.
  always_comb begin
    full_s     = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    overflow_s = signed_overflow(a[WIDTH-1], b[WIDTH-1], full_s[WIDTH-1]);
    zero_s     = (full_s == {(WIDTH+1){1'b0}});
  end

  // Output stage: reset wins, a valid beat captures, an idle beat holds data and drops valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result_r    <= {(WIDTH+1){1'b0}};
      overflow_r  <= 1'b0;
      zero_r      <= 1'b1;
      out_valid_r <= 1'b0;
    end else if (in_valid) begin
      result_r    <= full_s;
      overflow_r  <= overflow_s;
      zero_r      <= zero_s;
      out_valid_r <= 1'b1;
    end else begin
      result_r    <= result_r;
      overflow_r  <= overflow_r;
      zero_r      <= zero_r;
      out_valid_r <= 1'b0;
    end
  end

  // sum and cout are slices of the one result register, so result == {cout, sum} by construction.
  assign sum       = result_r[WIDTH-1:0];
  assign cout      = result_r[WIDTH];
  assign result    = result_r;
  assign overflow  = overflow_r;
  assign zero      = zero_r;
  assign out_valid = out_valid_r;

endmodule

// File: tb/tb_adder.sv
// Scoreboard bench for adder at WIDTH=8 (directed + random) and WIDTH=1/64 (random).
module tb_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        iv8, c8, ov8, cout8, ovf8, zero8;
  logic [7:0]  a8, b8, sum8;
  logic [8:0]  res8;

  logic        iv1, c1, ov1, cout1, ovf1, zero1;
  logic [0:0]  a1, b1, sum1;
  logic [1:0]  res1;

  logic        iv64, c64, ov64, cout64, ovf64, zero64;
  logic [63:0] a64, b64, sum64;
  logic [64:0] res64;

  adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .a(a8), .b(b8), .cin(c8),
    .sum(sum8), .cout(cout8), .result(res8), .overflow(ovf8), .zero(zero8), .out_valid(ov8));

  adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .a(a1), .b(b1), .cin(c1),
    .sum(sum1), .cout(cout1), .result(res1), .overflow(ovf1), .zero(zero1), .out_valid(ov1));

  adder #(.WIDTH(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv64), .a(a64), .b(b64), .cin(c64),
    .sum(sum64), .cout(cout64), .result(res64), .overflow(ovf64), .zero(zero64), .out_valid(ov64));

  int vectors = 0;
  int miscompares = 0;

  // Scoreboard entries are {zero, overflow, result[64:0]}, result zero-extended.
  logic [66:0] sb8[$];
  logic [66:0] sb1[$];
  logic [66:0] sb64[$];
  logic [66:0] last8, last1, last64;
  logic        exp_v8, exp_v1, exp_v64;
  localparam logic [66:0] RESET_EXP = {1'b1, 1'b0, 65'd0};

  // Reference: overflow as carry-into-MSB xor carry-out of the MSB.
  function automatic logic [66:0] model(input int w, input logic [63:0] a, input logic [63:0] b,
                                        input logic c);
    logic [64:0] r;
    logic        c_msb;
    r     = {1'b0, a} + {1'b0, b} + {64'd0, c};
    c_msb = r[w-1] ^ a[w-1] ^ b[w-1];
    return {(r == 65'd0), c_msb ^ r[w], r};
  endfunction

  task automatic drive8(input logic r, input logic v, input logic [7:0] a, input logic [7:0] b,
                        input logic c);
    @(negedge clk);
    rst_n = r; iv8 = v; a8 = a; b8 = b; c8 = c;
    iv1 = 1'b0; iv64 = 1'b0;
    exp_v8 = r && v;
    if (!r) begin
      sb8.delete(); sb1.delete(); sb64.delete();
      last8 = RESET_EXP; last1 = RESET_EXP; last64 = RESET_EXP;
    end else if (v) begin
      sb8.push_back(model(8, 64'(a), 64'(b), c));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive8(1'b0, 1'b1, 8'hFF, 8'h00, 1'b0);
      vectors++;
      if (ov8 !== 1'b0 || res8 !== 9'h000 || zero8 !== 1'b1 || sum8 !== 8'h00 || cout8 !== 1'b0 ||
          ovf8 !== 1'b0) begin
        miscompares++;
        $display("FAIL reset: got v=%b res=%h z=%b o=%b, want v=0 res=000 z=1 o=0", ov8, res8, zero8, ovf8);
      end
    end
    drive8(1'b1, 1'b0, 8'h55, 8'hAA, 1'b1);
    vectors++;
    if (ov8 !== 1'b0 || {zero8, ovf8, 65'(res8)} !== last8) begin
      miscompares++;
      $display("FAIL reset_release: got v=%b res=%h z=%b, want v=0 res=000 z=1", ov8, res8, zero8);
    end
  endtask

  task automatic test_basic();
    logic [7:0] ta[3] = '{8'd1, 8'd7, 8'd7};
    logic [7:0] tb[3] = '{8'd4, 8'd2, 8'd8};
    logic       tc[3] = '{1'b0, 1'b1, 1'b0};
    logic [8:0] tr[3] = '{9'h005, 9'h00A, 9'h00F};
    for (int i = 0; i < 3; i++) begin
      drive8(1'b1, 1'b1, ta[i], tb[i], tc[i]);
      vectors++;
      if (ov8 !== 1'b1) begin
        miscompares++;
        $display("FAIL basic_valid[%0d]: got %b want 1", i, ov8);
      end
      last8 = (sb8.size() > 0) ? sb8.pop_front() : {67{1'bx}};
      vectors++;
      if ({zero8, ovf8, 65'(res8)} !== last8 || 65'({cout8, sum8}) !== last8[64:0] || res8 !== tr[i]) begin
        miscompares++;
        $display("FAIL basic[%0d]: got res=%h sum=%h cout=%b, want res=%h", i, res8, sum8, cout8, tr[i]);
      end
    end
  endtask

  task automatic test_carry_overflow();
    logic [7:0] ta[5] = '{8'hFF, 8'hFF, 8'h7F, 8'h80, 8'hFF};
    logic [7:0] tb[5] = '{8'h01, 8'hFF, 8'h01, 8'h80, 8'h01};
    logic       tc[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    // Literal {zero, overflow, result} from the worked examples.
    logic [10:0] te[5] = '{{2'b00, 9'h100}, {2'b00, 9'h1FF}, {2'b01, 9'h080}, {2'b01, 9'h100},
                           {2'b00, 9'h100}};
    for (int i = 0; i < 5; i++) begin
      drive8(1'b1, 1'b1, ta[i], tb[i], tc[i]);
      last8 = (sb8.size() > 0) ? sb8.pop_front() : {67{1'bx}};
      vectors++;
      if (ov8 !== 1'b1 || {zero8, ovf8, 65'(res8)} !== last8 || 65'({cout8, sum8}) !== last8[64:0] ||
          {zero8, ovf8, res8} !== te[i]) begin
        miscompares++;
        $display("FAIL carry_ovf[%0d]: got v=%b z=%b o=%b res=%h, want v=1 z/o/res=%h",
                 i, ov8, zero8, ovf8, res8, te[i]);
      end
    end
  endtask

  task automatic test_hold();
    drive8(1'b1, 1'b1, 8'h3C, 8'h41, 1'b1);
    last8 = (sb8.size() > 0) ? sb8.pop_front() : {67{1'bx}};
    vectors++;
    if (ov8 !== 1'b1 || {zero8, ovf8, 65'(res8)} !== last8) begin
      miscompares++;
      $display("FAIL hold_setup: got v=%b res=%h, want v=1 res=%h", ov8, res8, last8[8:0]);
    end
    for (int i = 0; i < 4; i++) begin
      drive8(1'b1, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
      vectors++;
      if (ov8 !== 1'b0 || {zero8, ovf8, 65'(res8)} !== last8 || 65'({cout8, sum8}) !== last8[64:0]) begin
        miscompares++;
        $display("FAIL hold[%0d]: got v=%b z=%b o=%b res=%h, want v=0 res=%h", i, ov8, zero8, ovf8,
                 res8, last8[8:0]);
      end
    end
  endtask

  task automatic test_midstream_reset();
    drive8(1'b1, 1'b1, 8'h90, 8'h22, 1'b0);
    last8 = (sb8.size() > 0) ? sb8.pop_front() : {67{1'bx}};
    drive8(1'b0, 1'b1, 8'h12, 8'h34, 1'b1);
    vectors++;
    if (ov8 !== 1'b0 || {zero8, ovf8, 65'(res8)} !== RESET_EXP) begin
      miscompares++;
      $display("FAIL midstream_reset: got v=%b z=%b res=%h, want v=0 z=1 res=000", ov8, zero8, res8);
    end
    drive8(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      rst_n = 1'b1;
      iv8  = ($urandom_range(0, 3) != 0); a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
      iv1  = ($urandom_range(0, 3) != 0); a1 = 1'($urandom); b1 = 1'($urandom); c1 = 1'($urandom);
      iv64 = ($urandom_range(0, 3) != 0); a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom};
      c64  = 1'($urandom);
      if (i % 64 == 0) begin a64 = '1; b64 = '1; c64 = 1'b1; end
      exp_v8 = iv8; exp_v1 = iv1; exp_v64 = iv64;
      if (iv8)  sb8.push_back(model(8, 64'(a8), 64'(b8), c8));
      if (iv1)  sb1.push_back(model(1, 64'(a1), 64'(b1), c1));
      if (iv64) sb64.push_back(model(64, a64, b64, c64));
      @(posedge clk);
      #1;
      if (ov8)  last8  = (sb8.size() > 0)  ? sb8.pop_front()  : {67{1'bx}};
      if (ov1)  last1  = (sb1.size() > 0)  ? sb1.pop_front()  : {67{1'bx}};
      if (ov64) last64 = (sb64.size() > 0) ? sb64.pop_front() : {67{1'bx}};
      vectors++;
      if (ov8 !== exp_v8 || {zero8, ovf8, 65'(res8)} !== last8 || 65'({cout8, sum8}) !== last8[64:0]) begin
        miscompares++;
        $display("FAIL rand8[%0d]: got v=%b z=%b o=%b res=%h, want v=%b z/o/res=%h", i, ov8, zero8,
                 ovf8, res8, exp_v8, last8[66:0]);
      end
      vectors++;
      if (ov1 !== exp_v1 || {zero1, ovf1, 65'(res1)} !== last1 || 65'({cout1, sum1}) !== last1[64:0]) begin
        miscompares++;
        $display("FAIL rand1[%0d]: got v=%b z=%b o=%b res=%h, want v=%b z/o/res=%h", i, ov1, zero1,
                 ovf1, res1, exp_v1, last1);
      end
      vectors++;
      if (ov64 !== exp_v64 || {zero64, ovf64, res64} !== last64 || {cout64, sum64} !== last64[64:0]) begin
        miscompares++;
        $display("FAIL rand64[%0d]: got v=%b z=%b o=%b res=%h, want v=%b z/o/res=%h", i, ov64,
                 zero64, ovf64, res64, exp_v64, last64);
      end
    end
    if (sb8.size() != 0 || sb1.size() != 0 || sb64.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: left %0d/%0d/%0d, want 0/0/0", sb8.size(), sb1.size(), sb64.size());
    end
    vectors++;
  endtask

  initial begin
    rst_n = 1'b0;
    iv8 = 1'b1; a8 = 8'hFF; b8 = 8'h00; c8 = 1'b0;
    iv1 = 1'b0; a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
    iv64 = 1'b0; a64 = 64'd0; b64 = 64'd0; c64 = 1'b0;
    last8 = RESET_EXP; last1 = RESET_EXP; last64 = RESET_EXP;
    test_reset();
    test_basic();
    test_carry_overflow();
    test_hold();
    test_midstream_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/adder.md
Name: adder

Overview:
- Registered unsigned/two's-complement adder: computes a + b + cin over WIDTH bits with a carry-out and a (WIDTH+1)-bit combined result.
- Single-cycle registered datapath stage with a valid qualifier. Used as a leaf arithmetic block wherever a synchronous add with carry-in/carry-out is needed.
- Default configuration is 8-bit.

Parameters:
- WIDTH, 8, operand and sum width in bits (legal range 1..64).

Ports:
- clk  input  1  rising-edge clock for all state.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- in_valid  input  1  high marks a, b and cin as valid for capture this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in.
- sum  output  WIDTH  registered low WIDTH bits of a + b + cin.
- cout  output  1  registered carry-out (bit WIDTH of the full sum).
- result  output  WIDTH+1  registered full sum; always equals {cout, sum}.
- overflow  output  1  registered signed overflow: operands share a sign and sum's sign differs from it.
- zero  output  1  registered flag, high when result == 0.
- out_valid  output  1  high when outputs hold the sum of a captured transaction.

Behaviour:
- Reset: if rst_n is low at a rising clk edge, then next state is sum=0, cout=0, result=0, overflow=0, zero=1 and out_valid=0. Reset wins over in_valid in the same cycle. Reset mid-stream discards any in-flight result.
- Capture: on a rising edge with rst_n=1 and in_valid=1:
  - result <= a + b + cin, computed at WIDTH+1 bits with zero-extended operands.
  - sum <= result[WIDTH-1:0]; cout <= result[WIDTH].
  - overflow <= (a[MSB]==b[MSB]) && (sum[MSB]!=a[MSB]).
  - zero <= (result==0).
  - out_valid <= 1.
- Latency: exactly 1 cycle from the capturing edge; outputs are visible immediately after that edge. Throughput is 1 transaction per cycle, with back-to-back in_valid supported and no bubbles.
- Idle: on a rising edge with rst_n=1 and in_valid=0, out_valid <= 0. sum, cout, result, overflow and zero hold their previous values.
- Output timing: outputs are registered only; there is no combinational path from inputs to outputs.
- Arithmetic: wrap-around is modulo 2^WIDTH on sum, with the lost bit reported on cout. The maximum result is 2^(WIDTH+1)-1 (all-ones operands with cin=1).
- Inputs while in_valid=0 are don't-care and must not affect state.
- Implementation freedom: internal adder structure is free (ripple or lookahead), but it must close timing in one cycle at WIDTH=64.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in_valid=1, a=8'hFF -> out_valid=0, result=0, zero=1. Release reset -> outputs update only on the next in_valid edge.
- Basic adds, back-to-back over 3 cycles: (a=1, b=4, cin=0) -> sum=5, cout=0, result=9'h005. Then (7, 2, 1) -> sum=10, result=9'h00A. Then (7, 8, 0) -> sum=15, result=9'h00F. Each result appears 1 cycle after capture, with out_valid high all three cycles.
- Carry/wrap: (a=8'hFF, b=1, cin=0) -> sum=0, cout=1, result=9'h100, zero=0. (8'hFF, 8'hFF, 1) -> sum=8'hFF, cout=1, result=9'h1FF.
- Signed overflow: (8'h7F, 1, 0) -> sum=8'h80, overflow=1, cout=0. (8'h80, 8'h80, 0) -> sum=0, cout=1, overflow=1, zero=0. (8'hFF, 1, 0) -> overflow=0.
- Hold/idle: after a valid add, drop in_valid and toggle a/b/cin randomly -> out_valid=0 next cycle, and sum, cout, result, overflow and zero remain unchanged.
- Randomized self-check: 10k random (a, b, cin, in_valid) vectors against a reference model -> result == {cout, sum} == a+b+cin for every captured vector. Repeat at WIDTH=1 and WIDTH=64.
